// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel transfer counters are built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = $clog2(CHANNELS),
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
`ifdef STREAM_DEMUX_CNT_EN
   output logic [CHANNELS*CNT_W-1:0] out_cnt,
`endif
   output logic                      err_sel
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_t;

   logic                in_fire;
   logic                sel_oob;
   logic                sel_ready;
   logic [CHANNELS-1:0] hit;
   logic [CHANNELS-1:0] take;

   // Elaboration-time parameter sanity checks
   if (WIDTH < 1) begin : g_chk_width
      $error("stream_demux: WIDTH must be at least 1");
   end
   if (CHANNELS < 2 || CHANNELS > 16) begin : g_chk_channels
      $error("stream_demux: CHANNELS must be in 2..16");
   end
   if (CNT_W < 1) begin : g_chk_cnt_w
      $error("stream_demux: CNT_W must be at least 1");
   end

   // Out-of-range selects are always accepted and dropped
   assign sel_oob = (32'(in_sel) >= CHANNELS);

   always_comb begin
      sel_ready = 1'b1;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_ready = !out_valid[k] || out_ready[k];
         end
      end
      in_ready = !rst && (sel_oob || sel_ready);
   end

   assign in_fire = in_valid && in_ready;
   assign take    = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_sel <= 1'b0;
      end else if (in_fire && sel_oob) begin
         err_sel <= 1'b1;
      end
   end

   for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_ch
      ch_state_t        state_q;
      ch_state_t        state_d;
      logic             load;
      logic             valid_k;
      logic [WIDTH-1:0] data_q;

      assign hit[k] = in_fire && (in_sel == SEL_W'(k));

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= EMPTY;
         end else begin
            state_q <= state_d;
         end
      end

      // A reload while FULL is only possible when the consumer takes the old word
      always_comb begin
         state_d = state_q;
         load    = 1'b0;
         case (state_q)
            EMPTY: begin
               if (hit[k]) begin
                  state_d = FULL;
                  load    = 1'b1;
               end
            end
            FULL: begin
               if (hit[k]) begin
                  load = 1'b1;
               end else if (take[k]) begin
                  state_d = EMPTY;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      always_comb begin
         valid_k = (state_q == FULL);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            data_q <= '0;
         end else if (load) begin
            data_q <= in_data;
         end
      end

      assign out_valid[k]                = valid_k;
      assign out_data[k*WIDTH +: WIDTH]  = data_q;

`ifdef STREAM_DEMUX_CNT_EN
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (take[k]) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign out_cnt[k*CNT_W +: CNT_W] = cnt_q;
`endif
   end

endmodule
